floor_request_encoder: RTL and testbench

FLOOR_REQUEST_ENCODER -- requirements
Module: floor_request_encoder

---
 rtl/floor_request_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_floor_request_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/floor_request_encoder.sv
// Single-car elevator controller. It latches floor calls, chooses a travel
// direction, steps the car one floor per TRAVEL_TICKS tick pulses and holds
// the door open for DOOR_TICKS tick pulses. The current floor is exported as
// a 3-bit code (a2 a1 a0) for the seven-segment decoder.
module floor_request_encoder #(
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] req,
    output logic       a2,
    output logic       a1,
    output logic       a0,
    output logic [7:0] pending,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open
);

    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    // Any call strictly above floor f.
    function automatic logic above_of(input logic [7:0] pr, input logic [2:0] f);
        logic [7:0] mask;
        mask = ~((8'h02 << f) - 8'h01);
        return |(pr & mask);
    endfunction

    // Any call strictly below floor f.
    function automatic logic below_of(input logic [7:0] pr, input logic [2:0] f);
        logic [7:0] mask;
        mask = (8'h01 << f) - 8'h01;
        return |(pr & mask);
    endfunction

    // Selection rule: serve here, else keep last direction, else reverse, else idle.
    function automatic state_t select_next(input logic here, input logic above,
                                           input logic below, input logic dir_up);
        state_t nxt;
        if (here) begin
            nxt = ST_DOOR;
        end else if (dir_up && above) begin
            nxt = ST_UP;
        end else if (!dir_up && below) begin
            nxt = ST_DOWN;
        end else if (above) begin
            nxt = ST_UP;
        end else if (below) begin
            nxt = ST_DOWN;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    state_t          state_q,    state_d;
    logic [2:0]      floor_q,    floor_d;
    logic [7:0]      pending_q,  pending_d;
    logic            last_dir_q, last_dir_d;   // 1 = up
    logic [TW-1:0]   travel_q,   travel_d;
    logic [DW-1:0]   door_q,     door_d;
    logic            up_q,       up_d;
    logic            down_q,     down_d;
    logic            dopen_q,    dopen_d;

    logic [7:0]      pr_s;
    logic            enter_s;
    state_t          sel_s;

    // Next-state, floor, counter and pending computation.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        travel_d   = travel_q;
        door_d     = door_q;
        last_dir_d = last_dir_q;
        enter_s    = 1'b0;
        sel_s      = ST_IDLE;
        pr_s       = pending_q | req;

        case (state_q)
            ST_IDLE: begin
                sel_s = select_next(pr_s[floor_q], above_of(pr_s, floor_q),
                                    below_of(pr_s, floor_q), last_dir_q);
                // Opening the door needs no tick; starting to move waits for one.
                if (sel_s == ST_DOOR) begin
                    state_d = ST_DOOR;
                    enter_s = 1'b1;
                end else if (tick && (sel_s != ST_IDLE)) begin
                    state_d = sel_s;
                    enter_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UP, ST_DOWN: begin
                if (tick) begin
                    if (travel_q == TRAVEL_LAST) begin
                        floor_d  = (state_q == ST_UP) ? (floor_q + 3'd1) : (floor_q - 3'd1);
                        travel_d = {TW{1'b0}};
                        // Arrival decision uses the floor just reached.
                        if (pr_s[floor_d]) begin
                            state_d = ST_DOOR;
                            enter_s = 1'b1;
                        end else if ((state_q == ST_UP) ? above_of(pr_s, floor_d)
                                                        : below_of(pr_s, floor_d)) begin
                            state_d = state_q;
                        end else begin
                            sel_s   = select_next(1'b0, above_of(pr_s, floor_d),
                                                  below_of(pr_s, floor_d), last_dir_q);
                            state_d = sel_s;
                            enter_s = (sel_s != ST_IDLE);
                        end
                    end else begin
                        travel_d = travel_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    travel_d = travel_q;
                end
            end
            ST_DOOR: begin
                if (pr_s[floor_q]) begin
                    // Call at this floor while open: hold the door, drop the call.
                    state_d = ST_DOOR;
                    enter_s = 1'b1;
                end else if (tick) begin
                    if (door_q == DOOR_LAST) begin
                        sel_s   = select_next(1'b0, above_of(pr_s, floor_q),
                                              below_of(pr_s, floor_q), last_dir_q);
                        state_d = sel_s;
                        enter_s = (sel_s != ST_IDLE);
                    end else begin
                        door_d = door_q + {{(DW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    door_d = door_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // State-entry side effects.
        if (enter_s) begin
            case (state_d)
                ST_UP: begin
                    last_dir_d = 1'b1;
                    travel_d   = {TW{1'b0}};
                end
                ST_DOWN: begin
                    last_dir_d = 1'b0;
                    travel_d   = {TW{1'b0}};
                end
                ST_DOOR: begin
                    door_d = {DW{1'b0}};
                end
                default: begin
                    door_d = door_q;
                end
            endcase
        end else begin
            last_dir_d = last_dir_d;
        end

        // Entering DOOR services the floor: clear its call and drop a same-edge press.
        if (enter_s && (state_d == ST_DOOR)) begin
            pending_d = pr_s & ~(8'h01 << floor_d);
        end else begin
            pending_d = pr_s;
        end

        up_d    = (state_d == ST_UP);
        down_d  = (state_d == ST_DOWN);
        dopen_d = (state_d == ST_DOOR);
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            floor_q    <= 3'd0;
            pending_q  <= 8'h00;
            last_dir_q <= 1'b1;
            travel_q   <= {TW{1'b0}};
            door_q     <= {DW{1'b0}};
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            dopen_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            pending_q  <= pending_d;
            last_dir_q <= last_dir_d;
            travel_q   <= travel_d;
            door_q     <= door_d;
            up_q       <= up_d;
            down_q     <= down_d;
            dopen_q    <= dopen_d;
        end
    end

    assign a2          = floor_q[2];
    assign a1          = floor_q[1];
    assign a0          = floor_q[0];
    assign pending     = pending_q;
    assign moving_up   = up_q;
    assign moving_down = down_q;
    assign door_open   = dopen_q;

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed bench for floor_request_encoder with TRAVEL_TICKS=4, DOOR_TICKS=3.
module tb_floor_request_encoder;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] req;
    logic       a2, a1, a0;
    logic [7:0] pending;
    logic       moving_up, moving_down, door_open;

    int n_checks = 0;
    int n_fail   = 0;

    wire [2:0] floor_w = {a2, a1, a0};
    wire [2:0] st_w    = {moving_up, moving_down, door_open};

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_UP   = 3'b100;
    localparam logic [2:0] S_DOWN = 3'b010;
    localparam logic [2:0] S_DOOR = 3'b001;

    floor_request_encoder #(.TRAVEL_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
        .a2(a2), .a1(a1), .a0(a0), .pending(pending),
        .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b1; req = 8'h00;
        repeat (3) cyc();
        chk("rst_floor", 32'(floor_w), 32'd0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_status", 32'(st_w), 32'(S_IDLE));
        rst_n = 1'b1;
        cyc();

        // Single call to floor 5.
        req = 8'h20; cyc(); req = 8'h00;
        chk("c1_pending", 32'(pending), 32'h20);
        chk("c1_up", 32'(st_w), 32'(S_UP));
        for (int f = 1; f <= 5; f++) begin
            repeat (3) cyc();
            chk("c1_hold", 32'(floor_w), 32'(f - 1));
            cyc();
            chk("c1_step", 32'(floor_w), 32'(f));
            chk("c1_stat", 32'(st_w), 32'((f == 5) ? S_DOOR : S_UP));
        end
        chk("c1_pend_clr", 32'(pending), 32'h00);
        repeat (2) cyc();
        chk("c1_door3", 32'(st_w), 32'(S_DOOR));
        cyc();
        chk("c1_idle", 32'(st_w), 32'(S_IDLE));
        chk("c1_idle_fl", 32'(floor_w), 32'd5);

        // Calls at 0 and 7 from floor 5 with last_dir up.
        req = 8'h81; cyc(); req = 8'h00;
        chk("c2_pending", 32'(pending), 32'h81);
        chk("c2_up", 32'(st_w), 32'(S_UP));
        repeat (4) cyc();
        chk("c2_fl6", 32'(floor_w), 32'd6);
        chk("c2_pass6", 32'(st_w), 32'(S_UP));
        repeat (4) cyc();
        chk("c2_fl7", 32'(floor_w), 32'd7);
        chk("c2_door7", 32'(st_w), 32'(S_DOOR));
        chk("c2_pend7", 32'(pending), 32'h01);
        repeat (3) cyc();
        chk("c2_down", 32'(st_w), 32'(S_DOWN));
        for (int f = 6; f >= 0; f--) begin
            repeat (4) cyc();
            chk("c2_dfl", 32'(floor_w), 32'(f));
            chk("c2_dst", 32'(st_w), 32'((f == 0) ? S_DOOR : S_DOWN));
        end
        repeat (3) cyc();
        chk("c2_idle", 32'(st_w), 32'(S_IDLE));
        chk("c2_pend0", 32'(pending), 32'h00);

        // Go to floor 3 (last_dir down, only call above).
        req = 8'h08; cyc(); req = 8'h00;
        chk("c3_rev_up", 32'(st_w), 32'(S_UP));
        repeat (12) cyc();
        chk("c3_fl3", 32'(floor_w), 32'd3);
        repeat (3) cyc();
        chk("c3_idle", 32'(st_w), 32'(S_IDLE));
        // Call at the current floor opens the door with no movement.
        req = 8'h08; cyc(); req = 8'h00;
        chk("c3_door", 32'(st_w), 32'(S_DOOR));
        chk("c3_nomove", 32'(floor_w), 32'd3);
        chk("c3_drop", 32'(pending), 32'h00);
        cyc();
        req = 8'h08; cyc(); req = 8'h00;
        chk("c3_hold_pend", 32'(pending), 32'h00);
        cyc();
        chk("c3_restart1", 32'(st_w), 32'(S_DOOR));
        cyc();
        chk("c3_restart2", 32'(st_w), 32'(S_DOOR));
        cyc();
        chk("c3_close", 32'(st_w), 32'(S_IDLE));

        // Asynchronous reset with calls pressed: nothing captured.
        #3 rst_n = 1'b0; req = 8'hFF;
        cyc();
        chk("r2_pend", 32'(pending), 32'h00);
        chk("r2_floor", 32'(floor_w), 32'd0);
        req = 8'h00; rst_n = 1'b1;
        cyc();

        // Intermediate stop at floor 2 on the way to 6.
        req = 8'h40; cyc(); req = 8'h00;
        chk("c4_up", 32'(st_w), 32'(S_UP));
        repeat (4) cyc();
        chk("c4_fl1", 32'(floor_w), 32'd1);
        cyc();
        req = 8'h04; cyc(); req = 8'h00;
        chk("c4_pend", 32'(pending), 32'h44);
        repeat (2) cyc();
        chk("c4_fl2", 32'(floor_w), 32'd2);
        chk("c4_door2", 32'(st_w), 32'(S_DOOR));
        chk("c4_pend2", 32'(pending), 32'h40);
        repeat (3) cyc();
        chk("c4_resume", 32'(st_w), 32'(S_UP));
        repeat (16) cyc();
        chk("c4_fl6", 32'(floor_w), 32'd6);
        chk("c4_door6", 32'(st_w), 32'(S_DOOR));
        repeat (3) cyc();
        chk("c4_idle", 32'(st_w), 32'(S_IDLE));

        // Tick freeze mid-travel, then async reset while moving down at floor 4.
        req = 8'h01; cyc(); req = 8'h00;
        chk("c5_down", 32'(st_w), 32'(S_DOWN));
        repeat (4) cyc();
        chk("c5_fl5", 32'(floor_w), 32'd5);
        repeat (2) cyc();
        tick = 1'b0;
        repeat (20) cyc();
        chk("c5_frz_fl", 32'(floor_w), 32'd5);
        chk("c5_frz_st", 32'(st_w), 32'(S_DOWN));
        tick = 1'b1;
        cyc();
        chk("c5_cnt3", 32'(floor_w), 32'd5);
        cyc();
        chk("c5_fl4", 32'(floor_w), 32'd4);
        chk("c5_st4", 32'(st_w), 32'(S_DOWN));
        chk("c5_pend", 32'(pending), 32'h01);
        #3 rst_n = 1'b0;
        #1;
        chk("c6_floor", 32'(floor_w), 32'd0);
        chk("c6_pend", 32'(pending), 32'h00);
        chk("c6_status", 32'(st_w), 32'(S_IDLE));
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
